// File: rtl/weight_stream_sel.sv
// weight_stream_sel: sequenced, registered weight-slot streamer (valid/ready) for the MAC datapath.
// Optional range checking and the Err output are enabled by defining WSEL_BOUND_CHECK_EN.
module weight_stream_sel #(
    parameter int OUT_SIZE = 133,
    parameter int SEL_SIZE = 112,
    parameter int SEL_BIT  = 7,
    parameter int CNT_BIT  = 8
) (
    input  logic                         Clk,
    input  logic                         Rst_n,
    input  logic [OUT_SIZE*SEL_SIZE-1:0] In,
    input  logic                         Start,
    input  logic [SEL_BIT-1:0]           Base,
    input  logic [CNT_BIT-1:0]           Count,
    input  logic                         Mode,
    input  logic                         Abort,
    input  logic                         Out_Ready,
    output logic                         Out_Valid,
    output logic [OUT_SIZE-1:0]          Out,
    output logic [SEL_BIT-1:0]           Out_Index,
    output logic                         Out_Last,
    output logic                         Busy,
    output logic                         Done
`ifdef WSEL_BOUND_CHECK_EN
    ,
    output logic                         Err
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    localparam logic [SEL_BIT:0]   SEL_LIM = (SEL_BIT+1)'(SEL_SIZE);
    localparam logic [SEL_BIT-1:0] IDX_MAX = SEL_BIT'(SEL_SIZE - 1);
    localparam logic [CNT_BIT-1:0] REM_ONE = CNT_BIT'(1);

    state_t state, state_nxt;

    logic [SEL_SIZE-1:0][OUT_SIZE-1:0] bank;
    logic [SEL_BIT-1:0]                idx, idx_nxt;
    logic [CNT_BIT-1:0]                rem;
    logic                              mode_r;
    logic                              ld, in_range, reject, run_go, last_ld, acc;
    logic [OUT_SIZE-1:0]               slot;

    assign bank = In;

    // A load is allowed whenever the output register is empty or being drained this cycle.
    assign ld       = !Out_Valid || Out_Ready;
    assign acc      = Out_Valid && Out_Ready;
    assign in_range = {1'b0, idx} < SEL_LIM;
    assign slot     = in_range ? bank[idx] : bank[0];
    assign idx_nxt  = mode_r ? idx : ((idx == IDX_MAX) ? '0 : idx + 1'b1);
    assign last_ld  = (state == S_RUN) && ld && (rem == REM_ONE);

`ifdef WSEL_BOUND_CHECK_EN
    localparam logic [CNT_BIT:0] CNT_LIM = (CNT_BIT+1)'(SEL_SIZE);
    assign reject = ({1'b0, Base} >= SEL_LIM) || (!Mode && ({1'b0, Count} > CNT_LIM));
`else
    assign reject = 1'b0;
`endif

    assign run_go = Start && (Count != '0) && !reject;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (Abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (run_go)  state_nxt = S_RUN;
                S_RUN:   if (last_ld) state_nxt = S_DRAIN;
                S_DRAIN: if (acc)     state_nxt = S_IDLE;
                default:              state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        Busy = (state != S_IDLE);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            idx       <= '0;
            rem       <= '0;
            mode_r    <= 1'b0;
            Out_Valid <= 1'b0;
            Out       <= '0;
            Out_Index <= '0;
            Out_Last  <= 1'b0;
            Done      <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (Abort) begin
                Out_Valid <= 1'b0;
                Out_Last  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (run_go) begin
                            idx    <= Base;
                            rem    <= Count;
                            mode_r <= Mode;
                        end
                    end
                    S_RUN: begin
                        if (ld) begin
                            Out       <= slot;
                            Out_Index <= idx;
                            Out_Last  <= (rem == REM_ONE);
                            Out_Valid <= 1'b1;
                            rem       <= rem - 1'b1;
                            idx       <= idx_nxt;
                        end
                    end
                    S_DRAIN: begin
                        // The final beat stays registered until the consumer takes it.
                        if (acc) begin
                            Out_Valid <= 1'b0;
                            Out_Last  <= 1'b0;
                            Done      <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef WSEL_BOUND_CHECK_EN
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)                                   Err <= 1'b0;
        else if (Abort)                               Err <= 1'b0;
        else if (state == S_IDLE && Start && reject)  Err <= 1'b1;
        else                                          Err <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_weight_stream_sel.sv
// Scoreboard bench for weight_stream_sel: a run-level model queues expected beats, a monitor checks them.
module tb_weight_stream_sel;
    localparam int OUT_SIZE = 133;
    localparam int SEL_SIZE = 112;
    localparam int SEL_BIT  = 7;
    localparam int CNT_BIT  = 8;

    logic                         clk = 1'b0;
    logic                         rst_n;
    logic [OUT_SIZE*SEL_SIZE-1:0] bank;
    logic                         start, mode, abort_i, out_ready;
    logic [SEL_BIT-1:0]           base;
    logic [CNT_BIT-1:0]           count;
    logic                         out_valid, out_last, busy, done;
    logic [OUT_SIZE-1:0]          out_d;
    logic [SEL_BIT-1:0]           out_index;
`ifdef WSEL_BOUND_CHECK_EN
    logic                         err;
`endif

    always #5 clk = ~clk;

    weight_stream_sel #(.OUT_SIZE(OUT_SIZE), .SEL_SIZE(SEL_SIZE), .SEL_BIT(SEL_BIT), .CNT_BIT(CNT_BIT)) dut (
        .Clk(clk), .Rst_n(rst_n), .In(bank), .Start(start), .Base(base), .Count(count),
        .Mode(mode), .Abort(abort_i), .Out_Ready(out_ready), .Out_Valid(out_valid),
        .Out(out_d), .Out_Index(out_index), .Out_Last(out_last), .Busy(busy), .Done(done)
`ifdef WSEL_BOUND_CHECK_EN
        , .Err(err)
`endif
    );

    typedef struct {
        logic [SEL_BIT-1:0]  idx;
        logic [OUT_SIZE-1:0] data;
        logic                last;
    } beat_t;

    beat_t q[$];
    int    n_cmp = 0, n_bad = 0, n_pop = 0, cyc = 0, rdy_sel = 0;
    bit    m_busy = 1'b0, done_pend = 1'b0, exp_done;

    task automatic check_b(string name, logic act, logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_v(string name, logic [OUT_SIZE-1:0] act, logic [OUT_SIZE-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_i(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [OUT_SIZE-1:0] slot(int k);
        return bank[k*OUT_SIZE +: OUT_SIZE];
    endfunction

    task automatic fill_bank();
        logic [159:0] r;
        for (int k = 0; k < SEL_SIZE; k++) begin
            r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            bank[k*OUT_SIZE +: OUT_SIZE] = r[OUT_SIZE-1:0];
        end
    endtask

    // Expected run: count beats starting at base; step +1 wrapping at the bank end unless repeating.
    task automatic push_run(int b, int c, bit m);
        int    ix;
        beat_t t;
        ix = b;
        for (int i = 0; i < c; i++) begin
            t.idx  = SEL_BIT'(ix);
            t.data = (ix < SEL_SIZE) ? slot(ix) : slot(0);
            t.last = (i == c - 1);
            q.push_back(t);
            if (!m) ix = (ix == SEL_SIZE - 1) ? 0 : (ix + 1) % (1 << SEL_BIT);
        end
    endtask

    task automatic do_start(int b, int c, bit m, bit acc);
        start = 1'b1;
        base  = SEL_BIT'(b);
        count = CNT_BIT'(c);
        mode  = m;
        @(posedge clk); #1;
        start = 1'b0;
        base  = SEL_BIT'($urandom);
        count = CNT_BIT'($urandom);
        mode  = 1'($urandom);
        if (acc) begin
            push_run(b, c, m);
            m_busy = 1'b1;
        end
    endtask

    task automatic wait_idle(int lim);
        int n = 0;
        while ((q.size() != 0 || m_busy) && n < lim) begin
            @(posedge clk); #1;
            base  = SEL_BIT'($urandom);
            count = CNT_BIT'($urandom);
            mode  = 1'($urandom);
            n++;
        end
        if (n >= lim) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_idle: timeout with %0d beats pending", q.size());
            q.delete(); m_busy = 1'b0;
        end
    endtask

    // Start-to-Done latency with Out_Ready held high: first beat one edge after Start, then 1/cycle.
    task automatic run_timed(string name, int b, int c, bit m);
        int n = 0;
        do_start(b, c, m, 1'b1);
        check_b({name, "_lat0"}, out_valid, 1'b0);
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 1) check_b({name, "_lat1"}, out_valid, 1'b1);
        end while (!done && n < 60);
        check_i({name, "_done_cycles"}, n, c + 1);
        wait_idle(20);
    endtask

    always @(posedge clk) begin
        #1;
        cyc++;
        case (rdy_sel)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 9) < 7);
            2:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: out_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (rst_n) begin
            exp_done  = done_pend;
            done_pend = 1'b0;
            if (exp_done) m_busy = 1'b0;
            check_b("done", done, exp_done);
            check_b("busy", busy, m_busy);
            if (out_valid && !abort_i) begin
                if (q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL beat: unexpected beat idx %0d", out_index);
                end else begin
                    check_v("beat_idx", OUT_SIZE'(out_index), OUT_SIZE'(q[0].idx));
                    check_v("beat_data", out_d, q[0].data);
                    check_b("beat_last", out_last, q[0].last);
                    if (out_ready) begin
                        if (q[0].last) done_pend = 1'b1;
                        void'(q.pop_front());
                        n_pop++;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, n, b, c;
        bit m;
        rst_n = 1'b0; start = 1'b0; base = '0; count = '0; mode = 1'b0; abort_i = 1'b0;
        out_ready = 1'b1;
        fill_bank();
        repeat (3) @(posedge clk);
        #1;
        check_b("rst_valid", out_valid, 1'b0);
        check_v("rst_out", out_d, '0);
        check_v("rst_index", OUT_SIZE'(out_index), '0);
        check_b("rst_last", out_last, 1'b0);
        check_b("rst_done", done, 1'b0);
        check_b("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        rdy_sel = 0;
        @(posedge clk); #1;
        run_timed("inc", 5, 3, 1'b0);
        run_timed("wrap", 110, 4, 1'b0);

        rdy_sel = 2;
        p0 = n_pop;
        do_start(9, 4, 1'b1, 1'b1);
        wait_idle(100);
        check_i("repeat_handshakes", n_pop - p0, 4);

        rdy_sel = 0;
        @(posedge clk); #1;
        p0 = n_pop;
        do_start(40, 10, 1'b0, 1'b1);
        n = 0;
        while (n_pop - p0 < 2 && n < 50) begin @(posedge clk); #1; n++; end
        check_i("abort_pre_beats", n_pop - p0, 2);
        abort_i = 1'b1;
        start   = 1'b1;
        @(posedge clk); #1;
        abort_i = 1'b0;
        start   = 1'b0;
        q.delete(); m_busy = 1'b0; done_pend = 1'b0;
        check_b("abort_valid", out_valid, 1'b0);
        check_b("abort_last", out_last, 1'b0);
        check_b("abort_busy", busy, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        do_start(0, 1, 1'b0, 1'b1);
        wait_idle(20);

        do_start(7, 0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_b("cnt0_valid", out_valid, 1'b0);
        check_b("cnt0_busy", busy, 1'b0);
        rdy_sel = 1;
        do_start(20, 8, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        do_start(60, 5, 1'b0, 1'b0);
        wait_idle(200);

`ifdef WSEL_BOUND_CHECK_EN
        do_start(112, 3, 1'b0, 1'b0);
        check_b("bound_err", err, 1'b1);
        check_b("bound_busy", busy, 1'b0);
        @(posedge clk); #1;
        check_b("bound_err_clr", err, 1'b0);
`endif

        do_start(30, 20, 1'b0, 1'b1);
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_b("mid_rst_valid", out_valid, 1'b0);
        check_v("mid_rst_out", out_d, '0);
        check_v("mid_rst_index", OUT_SIZE'(out_index), '0);
        check_b("mid_rst_last", out_last, 1'b0);
        check_b("mid_rst_done", done, 1'b0);
        check_b("mid_rst_busy", busy, 1'b0);
        q.delete(); m_busy = 1'b0; done_pend = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_b("post_rst_valid", out_valid, 1'b0);
        check_b("post_rst_busy", busy, 1'b0);

        for (int r = 0; r < 40; r++) begin
            fill_bank();
            rdy_sel = $urandom_range(0, 1);
`ifdef WSEL_BOUND_CHECK_EN
            b = $urandom_range(0, SEL_SIZE - 1);
`else
            b = ($urandom_range(0, 7) == 0) ? $urandom_range(SEL_SIZE, (1 << SEL_BIT) - 1)
                                            : $urandom_range(0, SEL_SIZE - 1);
`endif
            c = $urandom_range(1, 25);
            m = 1'($urandom);
            do_start(b, c, m, 1'b1);
            wait_idle(400);
        end
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
